// File: rtl/gsm_uart_tx.sv
// gsm_uart_tx
// 8N1 UART transmitter placed downstream of the GSM AT-command sequencer.
// Each rising edge of tx_enable queues one byte in a small circular FIFO.
// Queued bytes are sent LSB first, and consecutive frames are sent with no
// idle gap between them. After each stop bit, tx_done pulses for one cycle.
module gsm_uart_tx #(
    parameter int unsigned BAUD_DIV   = 5208,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_enable,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       uart_txd,
    output logic       busy,
    output logic       ovf
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned BW   = $clog2(BAUD_DIV);

    localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Edge detector and FIFO storage
    logic                r_en_d;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CNTW-1:0]     r_count;
    logic                r_ovf;

    // Frame sequencer
    state_t              r_state;
    state_t              w_state_next;
    logic [BW-1:0]       r_baud_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shreg;

    // Registered outputs
    logic                r_txd;
    logic                r_done_pend;
    logic                r_tx_done;
    logic                r_busy;

    // Combinational control
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_nempty;
    logic                w_wr;
    logic                w_drop;
    logic                w_bit_end;
    logic                w_shift;
    logic                w_done_set;
    logic                w_txd;

    assign w_push    = tx_enable & ~r_en_d;
    assign w_full    = (r_count == FIFO_FULL);
    assign w_nempty  = (r_count != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted then.
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    // Edge-detect register for tx_enable and the sticky overflow flag
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en_d <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_en_d <= tx_enable;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // FIFO byte storage
    // NOTE: the data array has no reset; occupancy is defined by the pointers
    // and count, so leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy count; pointers wrap modulo the depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame FSM next-state, FIFO pop and line-level decode
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_shift      = 1'b0;
        w_done_set   = 1'b0;
        w_txd        = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_nempty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                w_txd = 1'b0;
                if (w_bit_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                w_txd = r_shreg[0];
                if (w_bit_end) begin
                    w_shift = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_done_set = 1'b1;
                    if (w_nempty) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Bit-period counter, data bit index and shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shreg    <= '0;
        end else begin
            if (w_pop || w_bit_end || r_state == IDLE) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + BW'(1);
            end

            if (r_state != DATA) begin
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_pop) begin
                r_shreg <= r_mem[r_rd_ptr];
            end else if (w_shift) begin
                r_shreg <= {1'b0, r_shreg[7:1]};
            end
        end
    end

    // Output registers. The line lags the FSM by one cycle. tx_done takes a
    // second stage so it lines up with the end of the stop bit on the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txd       <= 1'b1;
            r_done_pend <= 1'b0;
            r_tx_done   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_txd       <= w_txd;
            r_done_pend <= w_done_set;
            r_tx_done   <= r_done_pend;
            r_busy      <= (r_state != IDLE) | (r_count != '0);
        end
    end

    assign uart_txd = r_txd;
    assign tx_done  = r_tx_done;
    assign busy     = r_busy;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_gsm_uart_tx.sv
// Directed testbench for gsm_uart_tx.
// u_dut0 runs at BAUD_DIV=4 and covers the frame, hold, overflow,
// coincident push/pop and reset cases. u_dut1 runs at a scaled-down baud and
// sends "AT\r\n", keeping the sequencer-spacing to frame-length ratio.
module tb_gsm_uart_tx;

    localparam int B0     = 4;
    localparam int B1     = 104;
    localparam int SPACE1 = 1801;

    logic       clk = 1'b0;
    logic       rst;
    logic       en0, en1;
    logic [7:0] data0, data1;
    logic       done0, txd0, busy0, ovf0;
    logic       done1, txd1, busy1, ovf1;

    gsm_uart_tx #(.BAUD_DIV(B0), .FIFO_DEPTH(4)) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .tx_enable(en0),
        .tx_data  (data0),
        .tx_done  (done0),
        .uart_txd (txd0),
        .busy     (busy0),
        .ovf      (ovf0)
    );

    gsm_uart_tx #(.BAUD_DIV(B1), .FIFO_DEPTH(4)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .tx_enable(en1),
        .tx_data  (data1),
        .tx_done  (done1),
        .uart_txd (txd1),
        .busy     (busy1),
        .ovf      (ovf1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- line monitor (one per DUT, sampled on negedge) ----------
    int         m_pos      [2] = '{-1, -1};
    logic [9:0] m_bits     [2];
    bit         m_glitch   [2];
    int         m_fall     [2];
    bit         busy_prev  [2];
    int         rx_n       [2] = '{0, 0};
    int         done_n     [2] = '{0, 0};
    int         err_n      [2] = '{0, 0};
    logic [9:0] rx_bits    [2][64];
    int         fall_t     [2][64];
    int         done_t     [2][64];
    bit         done_busy  [2][64];
    bit         done_bprev [2][64];

    task automatic mon_step(input bit d);
        logic       txd_v;
        logic       done_v;
        logic       busy_v;
        int         baud;
        logic [3:0] bi;
        logic [5:0] slot;
        txd_v  = d ? txd1 : txd0;
        done_v = d ? done1 : done0;
        busy_v = d ? busy1 : busy0;
        baud   = d ? B1 : B0;
        if (!rst) begin
            m_pos[d] = -1;
        end else begin
            if (m_pos[d] < 0 && txd_v === 1'b0) begin
                m_pos[d]    = 0;
                m_fall[d]   = cyc;
                m_bits[d]   = '1;
                m_glitch[d] = 1'b0;
            end
            if (m_pos[d] >= 0) begin
                bi = 4'(m_pos[d] / baud);
                if (m_pos[d] % baud == 0) begin
                    m_bits[d][bi] = txd_v;
                end else if (txd_v !== m_bits[d][bi]) begin
                    m_glitch[d] = 1'b1;
                end
                if (m_pos[d] == 10 * baud - 1) begin
                    slot = 6'(rx_n[d]);
                    rx_bits[d][slot] = m_bits[d];
                    fall_t[d][slot]  = m_fall[d];
                    if (m_glitch[d] || m_bits[d][0] !== 1'b0 || m_bits[d][9] !== 1'b1) begin
                        err_n[d]++;
                    end
                    rx_n[d]++;
                    m_pos[d] = -1;
                end else begin
                    m_pos[d]++;
                end
            end
            if (done_v === 1'b1) begin
                slot = 6'(done_n[d]);
                done_t[d][slot]     = cyc;
                done_busy[d][slot]  = busy_v;
                done_bprev[d][slot] = busy_prev[d];
                done_n[d]++;
            end
        end
        busy_prev[d] = busy_v;
    endtask

    always @(negedge clk) begin
        mon_step(1'b0);
        mon_step(1'b1);
    end

    // ---------------- stimulus helpers ----------------------------------------
    int b_rx   [2];
    int b_done [2];
    int b_err  [2];

    task automatic snap();
        for (int d = 0; d < 2; d++) begin
            b_rx[d]   = rx_n[d];
            b_done[d] = done_n[d];
            b_err[d]  = err_n[d];
        end
    endtask

    // Called on a negedge: the edge is sampled at the next posedge (cyc+1),
    // and the task returns two negedges later.
    task automatic push(input bit d, input logic [7:0] b);
        if (d) begin
            data1 = b;
            en1   = 1'b1;
        end else begin
            data0 = b;
            en0   = 1'b1;
        end
        @(negedge clk);
        if (d) en1 = 1'b0;
        else   en0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input bit d, input int n, input int budget, input string tag);
        int start;
        start = cyc;
        while ((done_n[d] - b_done[d]) < n && (cyc - start) < budget) @(negedge clk);
        if ((done_n[d] - b_done[d]) < n) begin
            check(tag, 32'(done_n[d] - b_done[d]), 32'(n));
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [9:0] rx_at(input bit d, input int i);
        return rx_bits[d][6'(b_rx[d] + i)];
    endfunction

    function automatic int fall_at(input bit d, input int i);
        return fall_t[d][6'(b_rx[d] + i)];
    endfunction

    function automatic int done_at(input bit d, input int i);
        return done_t[d][6'(b_done[d] + i)];
    endfunction

    // ---------------- directed tests ------------------------------------------
    int               n_edge;
    logic [7:0]       at_str [4] = '{8'h41, 8'h54, 8'h0D, 8'h0A};

    initial begin
        rst   = 1'b0;
        en0   = 1'b0;
        en1   = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_txd",   32'(txd0),  32'd1);
        check("rst_done",  32'(done0), 32'd0);
        check("rst_busy",  32'(busy0), 32'd0);
        check("rst_ovf",   32'(ovf0),  32'd0);
        check("rst_txd1",  32'(txd1),  32'd1);
        check("rst_busy1", 32'(busy1), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 0x41: fall 2 cycles after the edge; tx_done 40 cycles after the fall
        snap();
        n_edge = cyc + 1;
        push(1'b0, 8'h41);
        wait_done(1'b0, 1, 100, "t1_timeout");
        repeat (10) @(negedge clk);
        check("t1_frames",   32'(rx_n[0] - b_rx[0]),     32'd1);
        check("t1_fall_lat", 32'(fall_at(0, 0) - n_edge), 32'd2);
        check("t1_bits",     32'(rx_at(0, 0)),            32'({1'b1, 8'h41, 1'b0}));
        check("t1_frm_err",  32'(err_n[0] - b_err[0]),    32'd0);
        check("t1_dones",    32'(done_n[0] - b_done[0]),  32'd1);
        check("t1_done_pos", 32'(done_at(0, 0) - fall_at(0, 0)), 32'd40);
        check("t1_busy_at_done", 32'(done_busy[0][6'(b_done[0])]),  32'd0);
        check("t1_busy_before",  32'(done_bprev[0][6'(b_done[0])]), 32'd1);

        // tx_enable held high for 200 cycles
        snap();
        data0 = 8'h55;
        en0   = 1'b1;
        repeat (200) @(negedge clk);
        en0 = 1'b0;
        repeat (30) @(negedge clk);
        check("t2_frames", 32'(rx_n[0] - b_rx[0]),    32'd1);
        check("t2_byte",   32'(rx_at(0, 0)),           32'({1'b1, 8'h55, 1'b0}));
        check("t2_dones",  32'(done_n[0] - b_done[0]), 32'd1);

        // Six edges 2 cycles apart into a depth-4 FIFO
        snap();
        for (int k = 1; k <= 5; k++) push(1'b0, 8'(k));
        check("t3_ovf_before", 32'(ovf0), 32'd0);
        push(1'b0, 8'h06);
        check("t3_ovf_after", 32'(ovf0), 32'd1);
        wait_done(1'b0, 5, 400, "t3_timeout");
        repeat (60) @(negedge clk);
        check("t3_frames", 32'(rx_n[0] - b_rx[0]),    32'd5);
        check("t3_dones",  32'(done_n[0] - b_done[0]), 32'd5);
        check("t3_frm_err", 32'(err_n[0] - b_err[0]),  32'd0);
        check("t3_ovf_sticky", 32'(ovf0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_byte%0d", i), 32'(rx_at(0, i)), 32'({1'b1, 8'(i + 1), 1'b0}));
        end
        for (int i = 1; i < 5; i++) begin
            check($sformatf("t3_gap%0d", i),  32'(fall_at(0, i) - fall_at(0, i - 1)), 32'd40);
            check($sformatf("t3_dgap%0d", i), 32'(done_at(0, i) - done_at(0, i - 1)), 32'd40);
        end

        // Full FIFO with a push landing on the STOP->START pop
        pulse_reset();
        check("t4_ovf_cleared", 32'(ovf0), 32'd0);
        snap();
        n_edge = cyc + 1;
        for (int k = 0; k < 5; k++) push(1'b0, 8'(8'h11 + k));
        while (cyc != n_edge + 40) @(negedge clk);
        push(1'b0, 8'h16);
        wait_done(1'b0, 6, 400, "t4_timeout");
        repeat (20) @(negedge clk);
        check("t4_ovf",    32'(ovf0), 32'd0);
        check("t4_frames", 32'(rx_n[0] - b_rx[0]),    32'd6);
        check("t4_dones",  32'(done_n[0] - b_done[0]), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t4_byte%0d", i), 32'(rx_at(0, i)), 32'({1'b1, 8'(8'h11 + i), 1'b0}));
        end
        check("t4_contig", 32'(fall_at(0, 5) - fall_at(0, 0)), 32'd200);

        // Reset in the middle of data bit 3 of 0xA5 (bit 3 is 0 on the line)
        snap();
        n_edge = cyc + 1;
        push(1'b0, 8'hA5);
        while (cyc != n_edge + 19) @(negedge clk);
        check("t5_line_bit3", 32'(txd0), 32'd0);
        rst = 1'b0;
        #1;
        check("t5_rst_txd",  32'(txd0),  32'd1);
        check("t5_rst_busy", 32'(busy0), 32'd0);
        check("t5_rst_done", 32'(done0), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        check("t5_no_done",  32'(done_n[0] - b_done[0]), 32'd0);
        check("t5_no_frame", 32'(rx_n[0] - b_rx[0]),     32'd0);
        check("t5_idle_txd", 32'(txd0), 32'd1);
        push(1'b0, 8'h0D);
        wait_done(1'b0, 1, 100, "t5_timeout");
        repeat (5) @(negedge clk);
        check("t5_frames",  32'(rx_n[0] - b_rx[0]), 32'd1);
        check("t5_byte",    32'(rx_at(0, 0)),        32'({1'b1, 8'h0D, 1'b0}));
        check("t5_frm_err", 32'(err_n[0] - b_err[0]), 32'd0);

        // "AT\r\n" at sequencer spacing on the slower instance
        snap();
        for (int k = 0; k < 4; k++) begin
            push(1'b1, at_str[k]);
            if (k < 3) repeat (SPACE1 - 2) @(negedge clk);
        end
        wait_done(1'b1, 4, 3000, "t6_timeout");
        repeat (20) @(negedge clk);
        check("t6_frames",  32'(rx_n[1] - b_rx[1]),    32'd4);
        check("t6_dones",   32'(done_n[1] - b_done[1]), 32'd4);
        check("t6_ovf",     32'(ovf1), 32'd0);
        check("t6_frm_err", 32'(err_n[1] - b_err[1]),   32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6_byte%0d", i), 32'(rx_at(1, i)), 32'({1'b1, at_str[i], 1'b0}));
            check($sformatf("t6_len%0d", i),  32'(done_at(1, i) - fall_at(1, i)), 32'(10 * B1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gsm_uart_tx.md
# gsm_uart_tx

Byte-serial UART transmitter that sits directly downstream of the GSM AT-command sequencer. It accepts one byte per rising edge of the sequencer's `tx_enable` and buffers up to FIFO_DEPTH bytes. Each byte is shifted out on `uart_txd` as an 8N1 frame to the GSM module. A one-cycle `tx_done` pulse is returned to the sequencer per completed frame.

## Interface
- BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600 baud); legal range 2..65535
- FIFO_DEPTH, 4, byte buffer entries; power of two, ≥2
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- tx_enable  input  1  byte strobe from sequencer; level signal, only its 0→1 edge is meaningful
- tx_data  input  8  byte to send; valid in the cycle `tx_enable` is first sampled high
- tx_done  output  1  one-cycle pulse at end of each frame's stop bit
- uart_txd  output  1  serial line, idle high
- busy  output  1  high while FIFO non-empty or a frame is in progress
- ovf  output  1  sticky overflow flag; cleared only by reset

## Operation
- Edge detect: register `en_d <= tx_enable`. Push condition is `tx_enable & ~en_d`. Holding `tx_enable` high never pushes a second byte.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr of log2(FIFO_DEPTH) bits, wrapping modulo depth.
  - Occupancy count has log2(FIFO_DEPTH)+1 bits.
  - Push when not full writes `tx_data`.
  - Push when full drops the byte and sets `ovf`. The FIFO is unchanged.
  - Simultaneous push and pop is legal in any state including full. Count is unchanged and both pointers advance; the incoming byte is not dropped.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `uart_txd`=1. If FIFO non-empty: pop into `shreg`, clear baud_cnt, go to START.
  - START: `uart_txd`=0 for BAUD_DIV cycles, then DATA with bit_idx=0.
  - DATA: `uart_txd`=`shreg[0]`, LSB first. Every BAUD_DIV cycles shift right and increment bit_idx. After bit 7's period go to STOP.
  - STOP: `uart_txd`=1 for BAUD_DIV cycles. On the last cycle, `tx_done` is registered high for the next cycle.
    - If FIFO non-empty: pop, go directly to START (no idle gap).
    - Else: go to IDLE.
- baud_cnt counts 0..BAUD_DIV-1 and wraps on each bit boundary. Width is clog2(BAUD_DIV).
- `busy` = (state≠IDLE) | (count≠0), registered.
- Upstream contract: per-character spacing from the sequencer is 90 001 cycles. This exceeds one frame (10·BAUD_DIV = 52 080 cycles at default), so the FIFO normally holds ≤1 byte.

## Timing
- Reset (async assert) forces:
  - `uart_txd`=1, `tx_done`=0, `busy`=0, `ovf`=0
  - FIFO emptied (pointers and count 0), state IDLE, `en_d`=0
- Reset mid-frame aborts the frame immediately; no `tx_done` is generated. Release is synchronous to clk.
- Latency:
  - Edge sampled at cycle N → FIFO write at N.
  - IDLE pop at N+1.
  - `uart_txd` falls at N+2 (registered output).
- Frame length is exactly 10·BAUD_DIV cycles from start-bit fall to end of stop bit.
- `tx_done` is high exactly 1 cycle, in the first cycle after the stop bit ends. It coincides with the next start bit when back-to-back.
- Back-to-back frames: stop bit of frame k is followed immediately by the start bit of frame k+1, with zero idle cycles.
- `ovf` sets in the cycle after the dropped push and stays set.
- A `tx_enable` edge during an active frame only enqueues; it never disturbs the current frame.

## Test plan
- BAUD_DIV=4, single edge with `tx_data`=0x41:
  - `uart_txd` falls 2 cycles later.
  - Line sequence 0,1,0,0,0,0,0,1,0,1, each bit lasting 4 cycles.
  - `tx_done` pulses once, 40 cycles after the fall. `busy` drops with it.
- BAUD_DIV=4, `tx_enable` held high for 200 cycles with `tx_data`=0x55 → exactly one frame and one `tx_done`.
- BAUD_DIV=4, FIFO_DEPTH=4, six edges 2 cycles apart with bytes 0x01..0x06:
  - Five frames 0x01..0x05 go out contiguously with no idle gap.
  - 0x06 is dropped and `ovf`=1.
  - Five `tx_done` pulses, spaced 40 cycles apart.
- Full FIFO plus a push coinciding with a STOP→START pop → byte accepted, `ovf` stays 0, all bytes emitted in order.
- Reset asserted mid-DATA bit 3:
  - `uart_txd`=1 and `busy`=0 immediately.
  - No `tx_done`.
  - After release, a new byte 0x0D transmits correctly.
- Default BAUD_DIV, "AT\r\n" (0x41,0x54,0x0D,0x0A) with edges every 90 001 cycles → four correct frames, four `tx_done` pulses, `ovf`=0.
